viterbi_seq_ctrl: RTL and testbench
===================================

// Module: viterbi_seq_ctrl
// PURPOSE
//   Sequencer for the Viterbi decoder datapath (BMU -> ACS -> PMU -> traceback).
//   Accepts the received-symbol stream via valid/ready, issues the per-symbol PMU update
//   strobe, requests path-metric normalisation, and hands fixed-length windows to the
//   traceback unit. Sits between the symbol input FIFO and the decoder core.
// PARAMETERS
//   PM_W      8    path-metric width (matches the PMU state registers)
//   NORM_THR  128  pm_min_i >= NORM_THR on an accepted symbol requests normalisation
//   TB_LEN    16   symbols per traceback window (>= 2)
//   TB_TMO    255  traceback watchdog limit in cycles (used only with the macro)
// PORTS
//   clk           in   1            clock, rising edge
//   rst_n         in   1            asynchronous reset, active low
//   start_i       in   1            frame start request, honoured in IDLE only
//   sym_valid_i   in   1            symbol present at the decoder input
//   sym_last_i    in   1            qualifies the final symbol of the frame
//   sym_ready_o   out  1            controller will accept a symbol this cycle
//   pm_min_i      in   PM_W         minimum of the four current path metrics (from PMU)
//   pmu_init_o    out  1            reload PMU with start metrics (S0=0, S1..S3=255)
//   pmu_valid_o   out  1            PMU/ACS update strobe (drives PMU valid_i)
//   norm_en_o     out  1            ACS subtracts pm_min_i during this update
//   tb_start_o    out  1            one-cycle traceback start pulse
//   tb_len_o      out  $clog2(TB_LEN+1)  symbols in the window handed to traceback
//   tb_done_i     in   1            traceback unit finished the window
//   busy_o        out  1            high in any state except IDLE
//   frame_done_o  out  1            one-cycle pulse when the frame is fully decoded
//   tmo_err_o     out  1            sticky traceback-timeout flag (macro only; else tied 0)
// BEHAVIOUR
//   - Reset: state IDLE; all outputs 0; symbol counter 0; last-seen flag 0.
//   - FSM states: IDLE, INIT, RUN, TB_START, TB_WAIT, DONE.
//   - IDLE: start_i=1 -> INIT. start_i outside IDLE ignored.
//   - INIT (1 cycle): pmu_init_o=1; counter cleared -> RUN.
//   - RUN: sym_ready_o=1. accept = sym_valid_i & sym_ready_o. On accept, same cycle:
//     pmu_valid_o=1; norm_en_o = (pm_min_i >= NORM_THR); counter += 1.
//   - Window close on accept when counter+1 == TB_LEN or sym_last_i=1: tb_len_o latches
//     counter+1, counter clears, last-seen flag latches sym_last_i -> TB_START.
//     Both conditions together -> a single traceback, then the frame ends.
//   - TB_START (1 cycle): tb_start_o=1, sym_ready_o=0; tb_done_i ignored -> TB_WAIT.
//   - TB_WAIT: sym_ready_o=0; tb_done_i=1 -> DONE if last-seen flag set, else RUN.
//   - DONE (1 cycle): frame_done_o=1; last-seen flag clears -> IDLE.
//   - tb_len_o holds its value until the next window close.
//   - pmu_valid_o, norm_en_o, tb_start_o, frame_done_o: never high for more than one
//     consecutive cycle per event; pmu_valid_o never high outside RUN.
//   - tb_done_i outside TB_WAIT ignored; sym_valid_i outside RUN not consumed.
//   - Counter cannot wrap: window close at TB_LEN bounds it.
//   - Reset mid-frame: immediate return to IDLE, outputs 0; no partial traceback issued.
// CONFIGURATION
//   VITERBI_TB_TIMEOUT_EN defined: cycle counter runs in TB_WAIT; TB_TMO cycles without
//     tb_done_i -> tmo_err_o=1 (sticky until rst_n), state -> IDLE, no frame_done_o.
//   Not defined: TB_WAIT waits indefinitely; tmo_err_o tied 0; no watchdog logic.
// TESTING (bench overrides TB_LEN=4)
//   1 Reset mid-RUN after 2 symbols -> all outputs 0, IDLE, busy_o=0 in the same cycle.
//   2 start, 4 symbols back-to-back, pm_min_i=10 -> 1-cycle pmu_init_o, 4 pmu_valid_o,
//     norm_en_o=0, tb_start_o on cycle after 4th accept, tb_len_o=4, sym_ready_o=0.
//   3 9 symbols, last on 9th, tb_done_i 3 cycles after each tb_start_o -> windows 4,4,1;
//     one frame_done_o after final tb_done_i; total pmu_valid_o count = 9.
//   4 pm_min_i=127 then 128 on consecutive accepts -> norm_en_o 0 then 1.
//   5 sym_last_i on 4th symbol -> single tb_start_o, tb_len_o=4, then frame_done_o.
//   6 macro on, TB_TMO=8, tb_done_i held 0 -> tmo_err_o=1 after 8 TB_WAIT cycles, IDLE,
//     no frame_done_o; start_i during TB_WAIT ignored throughout.

Source files
------------

// File: rtl/viterbi_seq_ctrl.sv
// viterbi_seq_ctrl: sequencer for the Viterbi decoder datapath (BMU -> ACS -> PMU -> traceback).
// Accepts symbols via valid/ready, strobes PMU updates, requests normalisation and
// hands fixed-length windows to the traceback unit.
// Optional feature: define VITERBI_TB_TIMEOUT_EN to enable the traceback watchdog
// (tmo_err_o); otherwise TB_WAIT waits indefinitely and tmo_err_o is tied low.
module viterbi_seq_ctrl #(
    parameter int unsigned PM_W     = 8,
    parameter int unsigned NORM_THR = 128,
    parameter int unsigned TB_LEN   = 16,
    parameter int unsigned TB_TMO   = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic                          sym_valid_i,
    input  logic                          sym_last_i,
    output logic                          sym_ready_o,
    input  logic [PM_W-1:0]               pm_min_i,
    output logic                          pmu_init_o,
    output logic                          pmu_valid_o,
    output logic                          norm_en_o,
    output logic                          tb_start_o,
    output logic [$clog2(TB_LEN+1)-1:0]   tb_len_o,
    input  logic                          tb_done_i,
    output logic                          busy_o,
    output logic                          frame_done_o,
    output logic                          tmo_err_o
);

    localparam int unsigned LEN_W = $clog2(TB_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_TB_START,
        S_TB_WAIT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [LEN_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  r_len;
    logic              r_last;
    logic              r_init;
    logic              r_ready;
    logic              r_tb_start;
    logic              r_done;
    logic              r_busy;

    logic              w_accept;
    logic              w_close;
    logic [LEN_W-1:0]  w_cnt_inc;
    logic              w_tmo;

    // Handshake and window-close decode; the update strobe follows the accept in the same cycle
    assign w_accept  = r_ready & sym_valid_i;
    assign w_cnt_inc = r_cnt + LEN_W'(1);
    assign w_close   = w_accept & ((w_cnt_inc == LEN_W'(TB_LEN)) | sym_last_i);

    assign pmu_valid_o  = w_accept;
    assign norm_en_o    = w_accept & (pm_min_i >= PM_W'(NORM_THR));
    assign sym_ready_o  = r_ready;
    assign pmu_init_o   = r_init;
    assign tb_start_o   = r_tb_start;
    assign tb_len_o     = r_len;
    assign busy_o       = r_busy;
    assign frame_done_o = r_done;

`ifdef VITERBI_TB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TB_TMO + 1);

    logic [TMO_W-1:0]  r_wait_cnt;
    logic              r_tmo_err;

    // Watchdog fires on the TB_TMO-th consecutive TB_WAIT cycle without tb_done_i
    assign w_tmo     = (r_state == S_TB_WAIT) & ~tb_done_i
                       & (r_wait_cnt == TMO_W'(TB_TMO - 1));
    assign tmo_err_o = r_tmo_err;

    // Count cycles spent in TB_WAIT; latch the sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_tmo_err  <= 1'b0;
        end else begin
            if (r_state == S_TB_WAIT) begin
                r_wait_cnt <= r_wait_cnt + TMO_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_tmo) begin
                r_tmo_err <= 1'b1;
            end
        end
    end
`else
    assign w_tmo     = 1'b0;
    assign tmo_err_o = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:     if (start_i) w_next = S_INIT;
            S_INIT:     w_next = S_RUN;
            S_RUN:      if (w_close) w_next = S_TB_START;
            S_TB_START: w_next = S_TB_WAIT;
            S_TB_WAIT: begin
                if (tb_done_i) begin
                    w_next = r_last ? S_DONE : S_RUN;
                end else if (w_tmo) begin
                    w_next = S_IDLE;
                end
            end
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Window symbol counter, traceback length and last-symbol flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_len  <= '0;
            r_last <= 1'b0;
        end else begin
            if (r_state == S_INIT) begin
                r_cnt  <= '0;
                r_last <= 1'b0;
            end else if (w_close) begin
                r_cnt  <= '0;
                r_len  <= w_cnt_inc;
                r_last <= sym_last_i;
            end else if (w_accept) begin
                r_cnt  <= w_cnt_inc;
            end else if ((r_state == S_DONE) || w_tmo) begin
                r_last <= 1'b0;
            end
        end
    end

    // State-decoded outputs, registered from the next state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init     <= 1'b0;
            r_ready    <= 1'b0;
            r_tb_start <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_init     <= (w_next == S_INIT);
            r_ready    <= (w_next == S_RUN);
            r_tb_start <= (w_next == S_TB_START);
            r_done     <= (w_next == S_DONE);
            r_busy     <= (w_next != S_IDLE);
        end
    end

endmodule

// File: tb/tb_viterbi_seq_ctrl.sv
// Bench for viterbi_seq_ctrl with TB_LEN=4, TB_TMO=8. A frame-level model predicts every
// output each cycle; directed frames add literal expectations on windows and strobe counts.
// The watchdog case runs only when VITERBI_TB_TIMEOUT_EN is defined.
module tb_viterbi_seq_ctrl;

    localparam int TB_LEN   = 4;
    localparam int TB_TMO   = 8;
    localparam int NORM_THR = 128;
    localparam int LEN_W    = $clog2(TB_LEN + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_i = 1'b0;
    logic             sym_valid_i = 1'b0;
    logic             sym_last_i = 1'b0;
    logic             sym_ready_o;
    logic [7:0]       pm_min_i = 8'd0;
    logic             pmu_init_o;
    logic             pmu_valid_o;
    logic             norm_en_o;
    logic             tb_start_o;
    logic [LEN_W-1:0] tb_len_o;
    logic             tb_done_i = 1'b0;
    logic             busy_o;
    logic             frame_done_o;
    logic             tmo_err_o;

    int n_chk  = 0;
    int n_pass = 0;

    viterbi_seq_ctrl #(
        .PM_W(8), .NORM_THR(NORM_THR), .TB_LEN(TB_LEN), .TB_TMO(TB_TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .sym_valid_i(sym_valid_i), .sym_last_i(sym_last_i), .sym_ready_o(sym_ready_o),
        .pm_min_i(pm_min_i), .pmu_init_o(pmu_init_o), .pmu_valid_o(pmu_valid_o),
        .norm_en_o(norm_en_o), .tb_start_o(tb_start_o), .tb_len_o(tb_len_o),
        .tb_done_i(tb_done_i), .busy_o(busy_o), .frame_done_o(frame_done_o),
        .tmo_err_o(tmo_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Observation records, cleared per test
    int cnt_init, cnt_pv, cnt_fd;
    int len_q[$];
    int norm_q[$];
    int cyc = 0;
    int t_tbs = -1;
    int t_tmo = -1;

    task automatic clear_obs();
        cnt_init = 0; cnt_pv = 0; cnt_fd = 0;
        len_q.delete(); norm_q.delete();
        t_tbs = -1; t_tmo = -1;
    endtask

    // Frame-level model: what phase of the frame we are in and what the window holds
    bit m_busy, m_ready, m_init, m_tbs, m_wait, m_fd, m_tmo, m_last;
    int m_win, m_len, m_wcnt;

    // Compare process: sample at the falling edge, check, then advance the model
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                m_busy = 0; m_ready = 0; m_init = 0; m_tbs = 0; m_wait = 0;
                m_fd = 0; m_tmo = 0; m_last = 0; m_win = 0; m_len = 0; m_wcnt = 0;
            end
            begin
                bit acc;
                acc = sym_valid_i && m_ready;
                chk("sym_ready",  int'(sym_ready_o),  int'(m_ready));
                chk("pmu_init",   int'(pmu_init_o),   int'(m_init));
                chk("pmu_valid",  int'(pmu_valid_o),  int'(acc));
                chk("norm_en",    int'(norm_en_o),    int'(acc && (int'(pm_min_i) >= NORM_THR)));
                chk("tb_start",   int'(tb_start_o),   int'(m_tbs));
                chk("tb_len",     int'(tb_len_o),     m_len);
                chk("busy",       int'(busy_o),       int'(m_busy));
                chk("frame_done", int'(frame_done_o), int'(m_fd));
                chk("tmo_err",    int'(tmo_err_o),    int'(m_tmo));
                if (rst_n) begin
                    if (pmu_init_o)   cnt_init++;
                    if (pmu_valid_o) begin cnt_pv++; norm_q.push_back(int'(norm_en_o)); end
                    if (tb_start_o)  begin len_q.push_back(int'(tb_len_o)); t_tbs = cyc; end
                    if (frame_done_o) cnt_fd++;
                    if (tmo_err_o && t_tmo < 0) t_tmo = cyc;
                    if (m_init) begin
                        m_init = 0; m_ready = 1; m_win = 0;
                    end else if (m_ready) begin
                        if (acc) begin
                            m_win++;
                            if (m_win == TB_LEN || sym_last_i) begin
                                m_len = m_win; m_last = sym_last_i; m_win = 0;
                                m_ready = 0; m_tbs = 1;
                            end
                        end
                    end else if (m_tbs) begin
                        m_tbs = 0; m_wait = 1; m_wcnt = 0;
                    end else if (m_wait) begin
                        if (tb_done_i) begin
                            m_wait = 0;
                            if (m_last) m_fd = 1;
                            else m_ready = 1;
                        end
`ifdef VITERBI_TB_TIMEOUT_EN
                        else begin
                            m_wcnt++;
                            if (m_wcnt == TB_TMO) begin
                                m_wait = 0; m_busy = 0; m_tmo = 1; m_last = 0;
                            end
                        end
`endif
                    end else if (m_fd) begin
                        m_fd = 0; m_busy = 0; m_last = 0;
                    end else if (start_i) begin
                        m_busy = 1; m_init = 1;
                    end
                end
            end
        end
    end

    // Traceback responder: pulse tb_done_i three cycles after each tb_start_o
    bit resp_en = 1'b1;
    initial begin
        forever begin
            @(negedge clk);
            if (resp_en && rst_n && tb_start_o) begin
                repeat (3) @(posedge clk);
                #1 tb_done_i = 1'b1;
                @(posedge clk);
                #1 tb_done_i = 1'b0;
            end
        end
    end

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
    endtask

    task automatic send_sym(input int pm, input bit last);
        bit seen;
        seen = 0;
        sym_valid_i = 1'b1; pm_min_i = 8'(pm); sym_last_i = last;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (sym_ready_o) seen = 1;
        end
        chk("sym_accept_ready", int'(sym_ready_o), 1);
        @(posedge clk); #1;
        sym_valid_i = 1'b0; sym_last_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit idle;
        idle = 0;
        for (int k = 0; k < budget && !idle; k++) begin
            @(negedge clk);
            if (!busy_o) idle = 1;
        end
        chk("idle_reached", int'(busy_o), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        @(posedge clk); #1 rst_n = 1'b1;
        clear_obs();
        @(posedge clk); #1;
    endtask

    initial begin
        clear_obs();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-RUN after two symbols, with a symbol still presented
        pulse_start();
        send_sym(10, 0);
        send_sym(10, 0);
        chk("t1_pv_before_reset", cnt_pv, 2);
        sym_valid_i = 1'b1; pm_min_i = 8'd200;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t1_busy",      int'(busy_o), 0);
        chk("t1_ready",     int'(sym_ready_o), 0);
        chk("t1_pmu_valid", int'(pmu_valid_o), 0);
        chk("t1_norm",      int'(norm_en_o), 0);
        chk("t1_tb_start",  int'(tb_start_o), 0);
        chk("t1_tb_len",    int'(tb_len_o), 0);
        sym_valid_i = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        clear_obs();
        @(posedge clk); #1;

        // Four back-to-back symbols fill one window
        pulse_start();
        for (int i = 0; i < 4; i++) send_sym(10, 0);
        @(negedge clk);
        chk("t2_tb_start", int'(tb_start_o), 1);
        chk("t2_tb_len",   int'(tb_len_o), 4);
        chk("t2_ready",    int'(sym_ready_o), 0);
        chk("t2_init_cnt", cnt_init, 1);
        chk("t2_pv_cnt",   cnt_pv, 4);
        chk("t2_norm_sum", norm_q.sum(), 0);
        do_reset();

        // Nine-symbol frame: windows 4,4,1 then one frame_done
        pulse_start();
        for (int i = 0; i < 9; i++) send_sym(20 + i, (i == 8));
        wait_idle(60);
        chk("t3_windows", len_q.size(), 3);
        if (len_q.size() == 3) begin
            chk("t3_win0", len_q[0], 4);
            chk("t3_win1", len_q[1], 4);
            chk("t3_win2", len_q[2], 1);
        end
        chk("t3_fd_cnt", cnt_fd, 1);
        chk("t3_pv_cnt", cnt_pv, 9);
        do_reset();

        // Normalisation threshold boundary on consecutive accepts
        pulse_start();
        send_sym(127, 0);
        send_sym(128, 1);
        wait_idle(40);
        chk("t4_norm_n", norm_q.size(), 2);
        if (norm_q.size() == 2) begin
            chk("t4_norm_127", norm_q[0], 0);
            chk("t4_norm_128", norm_q[1], 1);
        end
        chk("t4_fd_cnt", cnt_fd, 1);
        do_reset();

        // Last symbol coincides with a full window: one traceback then frame end
        pulse_start();
        for (int i = 0; i < 4; i++) send_sym(200, (i == 3));
        wait_idle(40);
        chk("t5_windows", len_q.size(), 1);
        if (len_q.size() == 1) chk("t5_win0", len_q[0], 4);
        chk("t5_fd_cnt", cnt_fd, 1);

`ifdef VITERBI_TB_TIMEOUT_EN
        do_reset();
        // Traceback never completes: watchdog returns to IDLE with sticky error
        resp_en = 1'b0;
        pulse_start();
        for (int i = 0; i < 4; i++) send_sym(50, 0);
        start_i = 1'b1;
        repeat (5) @(posedge clk);
        #1 start_i = 1'b0;
        wait_idle(40);
        chk("t6_tmo_err",  int'(tmo_err_o), 1);
        chk("t6_fd_cnt",   cnt_fd, 0);
        chk("t6_tmo_time", t_tmo - t_tbs, TB_TMO + 1);
        repeat (3) @(posedge clk);
        #1 chk("t6_tmo_sticky", int'(tmo_err_o), 1);
        resp_en = 1'b1;
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
